// File: rtl/collect_data_49_if.sv
// collect_data_49_if: router packet inputs, step key and display outputs of the collector
interface collect_data_49_if #(
    parameter int N_ROUTERS = 49,
    parameter int PKT_W     = 13
);
    logic [N_ROUTERS-1:0][PKT_W-1:0] in_router;
    logic                            key_next;
    logic [6:0]                      hex_router;
    logic [6:0]                      hex_step1;
    logic [6:0]                      hex_step2;
    logic                            disp_valid;
    logic [3:0]                      fifo_count;
    logic                            led_lost;
    modport master (
        output in_router, key_next,
        input  hex_router, hex_step1, hex_step2, disp_valid, fifo_count, led_lost
    );
    modport slave (
        input  in_router, key_next,
        output hex_router, hex_step1, hex_step2, disp_valid, fifo_count, led_lost
    );
endinterface

// File: rtl/collect_data_49.sv
// collect_data_49: captures newly delivered router packets into a FIFO and shows them one by one on 7-segment displays
module collect_data_49 #(
    parameter int N_ROUTERS  = 49,
    parameter int PKT_W      = 13,
    parameter int IDX_W      = 6,
    parameter int FIFO_DEPTH = 8
) (
    input logic              clk,
    input logic              rst_n,
    collect_data_49_if.slave bus
);
    localparam int PW = PKT_W - 1;
    localparam int EW = IDX_W + PW;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    logic [N_ROUTERS-1:0] prev_valid_q, prev_valid_d, pending_q, pending_d;
    logic [PW-1:0]        prev_payload_q [N_ROUTERS];
    logic [PW-1:0]        prev_payload_d [N_ROUTERS];
    logic [PW-1:0]        slot_q [N_ROUTERS];
    logic [PW-1:0]        slot_d [N_ROUTERS];
    logic [EW-1:0]        mem_q [FIFO_DEPTH];
    logic [EW-1:0]        mem_d [FIFO_DEPTH];
    logic [IDX_W-1:0]     ptr_q, ptr_d;
    logic [AW-1:0]        wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]        count_q, count_d;
    logic [EW-1:0]        disp_q, disp_d;
    logic                 disp_valid_q, disp_valid_d;
    logic                 led_lost_q, led_lost_d;
    logic                 key_q, key_d;
    logic [6:0]           hex_router_q, hex_router_d;
    logic [6:0]           hex_step1_q, hex_step1_d;
    logic [6:0]           hex_step2_q, hex_step2_d;
    logic                 push, pop, new_pkt, sel;

    function automatic logic [6:0] seg(input logic [5:0] v);
        case (v)
            6'd0:    return 7'h40;
            6'd1:    return 7'h79;
            6'd2:    return 7'h24;
            6'd3:    return 7'h30;
            6'd4:    return 7'h19;
            6'd5:    return 7'h12;
            6'd6:    return 7'h02;
            6'd7:    return 7'h78;
            6'd8:    return 7'h00;
            6'd9:    return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    // detect arrivals, scan pending slots into the FIFO, pop on key edge, encode display
    always_comb begin
        push = pending_q[ptr_q] && count_q != CW'(FIFO_DEPTH);
        pop = bus.key_next && !key_q && count_q != '0;
        new_pkt = 1'b0;
        sel = 1'b0;
        prev_valid_d = '0;
        pending_d = pending_q;
        led_lost_d = led_lost_q;
        for (int i = 0; i < N_ROUTERS; i++) begin
            new_pkt = bus.in_router[i][PW] && (!prev_valid_q[i] || bus.in_router[i][PW-1:0] != prev_payload_q[i]);
            sel = push && ptr_q == IDX_W'(i);
            prev_valid_d[i] = bus.in_router[i][PW];
            prev_payload_d[i] = bus.in_router[i][PW-1:0];
            slot_d[i] = new_pkt ? bus.in_router[i][PW-1:0] : slot_q[i];
            pending_d[i] = new_pkt || (pending_q[i] && !sel);
            led_lost_d = led_lost_d || (new_pkt && pending_q[i] && !sel);
        end
        for (int j = 0; j < FIFO_DEPTH; j++)
            mem_d[j] = (push && wr_q == AW'(j)) ? {ptr_q, slot_q[ptr_q]} : mem_q[j];
        ptr_d = ptr_q == IDX_W'(N_ROUTERS - 1) ? '0 : ptr_q + IDX_W'(1);
        wr_d = wr_q + AW'(push);
        rd_d = rd_q + AW'(pop);
        count_d = count_q + CW'(push) - CW'(pop);
        key_d = bus.key_next;
        disp_d = pop ? mem_q[rd_q] : disp_q;
        disp_valid_d = disp_valid_q || pop;
        hex_router_d = disp_valid_d ? seg(disp_d[EW-1:PW]) : 7'h7F;
        hex_step1_d = disp_valid_d ? seg(disp_d[PW-1:PW/2]) : 7'h7F;
        hex_step2_d = disp_valid_d ? seg(disp_d[PW/2-1:0]) : 7'h7F;
    end

    // control state with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prev_valid_q <= '0;
            prev_payload_q <= '{default: '0};
            pending_q <= '0;
            ptr_q <= '0;
            wr_q <= '0;
            rd_q <= '0;
            count_q <= '0;
            disp_q <= '0;
            disp_valid_q <= 1'b0;
            led_lost_q <= 1'b0;
            key_q <= 1'b0;
            hex_router_q <= 7'h7F;
            hex_step1_q <= 7'h7F;
            hex_step2_q <= 7'h7F;
        end else begin
            prev_valid_q <= prev_valid_d;
            prev_payload_q <= prev_payload_d;
            pending_q <= pending_d;
            ptr_q <= ptr_d;
            wr_q <= wr_d;
            rd_q <= rd_d;
            count_q <= count_d;
            disp_q <= disp_d;
            disp_valid_q <= disp_valid_d;
            led_lost_q <= led_lost_d;
            key_q <= key_d;
            hex_router_q <= hex_router_d;
            hex_step1_q <= hex_step1_d;
            hex_step2_q <= hex_step2_d;
        end
    end

    // payload storage, only meaningful when flagged by pending or FIFO count
    always_ff @(posedge clk) begin
        slot_q <= slot_d;
        mem_q <= mem_d;
    end

    assign bus.hex_router = hex_router_q;
    assign bus.hex_step1  = hex_step1_q;
    assign bus.hex_step2  = hex_step2_q;
    assign bus.disp_valid = disp_valid_q;
    assign bus.fifo_count = count_q;
    assign bus.led_lost   = led_lost_q;
endmodule
